dmem_access_arbiter: RTL
========================

// Module: dmem_access_arbiter
// PURPOSE
//  Shares the single-ported data memory between two requesters: port 0 (pipeline LSU) and port 1 (debug/DMA loader).
//  Accepts requests over a valid/ready handshake and arbitrates round-robin.
//  Drives the memory address/write-enable/write-data/func3 from registers, so they are stable for a full cycle.
//  Returns registered read data and an error flag; sits between the MEM stage and the data memory.
// PARAMETERS
//  ADDR_W     32    request/memory address width
//  DATA_W     32    data width
//  MEM_BYTES  4096  addressable bytes; addr >= MEM_BYTES is out of range
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  m0_valid       in   1       port 0 request valid
//  m0_ready       out  1       port 0 request accepted when valid&&ready
//  m0_we          in   1       1 = store, 0 = load
//  m0_addr        in   ADDR_W  byte address
//  m0_wdata       in   DATA_W  store data, right-aligned
//  m0_func3       in   3       RV32 load/store func3 (0 b, 1 h, 2 w, 4 bu, 5 hu)
//  m0_rvalid      out  1       one-cycle response pulse (loads and stores)
//  m0_rdata       out  DATA_W  load result, extended per func3; 0 for stores/errors
//  m0_err         out  1       qualifies m0_rvalid: misaligned, out-of-range or illegal func3
//  m1_*           --   --      identical set for port 1
//  memAddr        out  ADDR_W  to data memory
//  memWriteEnable out  1       to data memory; high only in ACCESS for a legal store
//  memWriteData   out  DATA_W  to data memory
//  func3          out  3       to data memory
//  memReadData    in   DATA_W  combinational read data from memory
// BEHAVIOUR
//  - Reset: FSM=IDLE, rr pointer=port 0, all outputs 0 except m*_ready (1 while in IDLE).
//  - FSM IDLE: ready=1 on both ports; grant one valid port (rr priority), latch its request, go to ACCESS.
//  - FSM ACCESS: drive the mem* outputs from latched registers for exactly one cycle;
//    capture memReadData at the clock edge; go to RESP.
//  - FSM RESP: granted port rvalid=1 for one cycle; ready=0; go to IDLE.
//  - Latency: accepted in cycle N, memory access in N+1, rvalid in N+2; throughput 1 request per 3 cycles.
//  - Arbitration: both valid -> grant the port named by rr, then point rr at the other port.
//    A single valid request is granted regardless of rr; rr flips only on a grant.
//  - Ungranted port: ready=0 outside IDLE. In IDLE, ready is asserted on the ungranted port too,
//    but that port's handshake does not complete; it holds valid/data and retries.
//  - Legality check at accept:
//    - misaligned: h with addr[0]!=0, w with addr[1:0]!=0;
//    - out of range: addr >= MEM_BYTES;
//    - illegal func3: 3, 6, 7, or store func3 > 2.
//    Illegal request -> skip ACCESS (IDLE->RESP), memWriteEnable stays 0, rvalid+err, rdata=0.
//  - Load extension: register capture of memReadData, which is already extended by memory func3 handling.
//  - Reset mid-transaction: the transaction is discarded; no rvalid; memWriteEnable drops asynchronously.
// CONFIGURATION
//  DMEM_MISALIGN_SPLIT_EN defined:
//  - Misaligned h/w are not errors; they are split into 2 or 4 byte accesses (func3=0 for sb, 4 for lbu)
//    at addr, addr+1, ...; byte counter in SPLIT state.
//  - Load bytes are assembled little-endian, then sign/zero-extended per original func3.
//  - Latency = 2 + number of bytes.
//  - Out of range checks the last byte; if any byte is out of range, no byte is written.
//  Undefined: misaligned -> err, as above; no SPLIT state.
// STRUCTURE
//  - Shared package Defines.v: AddrWidth, DataWidth, Func3Width, func3 encodings (F3_B/H/W/BU/HU), FSM state encodings.
//  - One sub-module dmem_rr_arb (2-way round-robin grant + pointer); the FSM and datapath stay in this module.
// TESTING
//  - Reset, then m0 sw addr 0x10 data 0xDEADBEEF -> ready, memWriteEnable 1 for exactly 1 cycle, m0_rvalid at N+2, err=0.
//  - m0 lb at 0x13 after the store -> rdata 0xFFFFFFDE; lbu -> 0x000000DE.
//  - m0 and m1 valid together for 4 requests -> grants alternate 0,1,0,1; neither starves.
//  - m1 lw addr 0x12 -> m1_err=1, rdata 0, memWriteEnable never high.
//    With DMEM_MISALIGN_SPLIT_EN: lw addr 0x12 over bytes 11 22 33 44 -> 0x44332211 after 6 cycles.
//  - sw addr 0x1000 (MEM_BYTES=4096) -> err=1, memory unchanged (read back 0x0FFC).
//  - rst asserted during ACCESS of a store -> memWriteEnable 0 immediately, no rvalid, FSM IDLE, rr=port 0.

Source files
------------

// File: rtl/dmem_access_arbiter_pkg.sv
// Shared types for the data-memory arbiter: widths, RV32 func3 encodings, FSM states.
// Split-access states exist only when DMEM_MISALIGN_SPLIT_EN is defined.
package dmem_access_arbiter_pkg;

  localparam int AddrWidth  = 32;
  localparam int DataWidth  = 32;
  localparam int Func3Width = 3;

  localparam logic [Func3Width-1:0] F3_B  = 3'd0;
  localparam logic [Func3Width-1:0] F3_H  = 3'd1;
  localparam logic [Func3Width-1:0] F3_W  = 3'd2;
  localparam logic [Func3Width-1:0] F3_BU = 3'd4;
  localparam logic [Func3Width-1:0] F3_HU = 3'd5;

`ifdef DMEM_MISALIGN_SPLIT_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_RESP   = 3'd2,
    ST_SPLIT  = 3'd3,
    ST_FIN    = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;
`endif

  // Unsigned loads have no store counterpart.
  function automatic logic f3_illegal(input logic we, input logic [Func3Width-1:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return we;
      default:          return 1'b1;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [Func3Width-1:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'd1) && a[0]) || ((f3 == F3_W) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin grant; the pointer moves to the port that was not granted.
// Combinational grant, pointer updates only on a grant while enabled.
module dmem_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic rr_q, rr_d;

  always_comb begin
    gnt  = 2'b00;
    rr_d = rr_q;
    if (advance) begin
      if (req == 2'b11) gnt = rr_q ? 2'b10 : 2'b01;
      else              gnt = req;
    end
    if (|gnt) rr_d = ~gnt[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Round-robin sharing of the data memory between LSU (m0) and loader (m1); DMEM_MISALIGN_SPLIT_EN splits misaligned h/w.
// Latency: accept N, memory N+1, rvalid N+2 (illegal: N+1; split: N+2+bytes); one request per 3 cycles.
// Backpressure: ready only in IDLE; an ungranted port holds its request and retries.
module dmem_access_arbiter
  import dmem_access_arbiter_pkg::*;
#(
  parameter int ADDR_W    = AddrWidth,
  parameter int DATA_W    = DataWidth,
  parameter int MEM_BYTES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic                  m0_we,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [Func3Width-1:0] m0_func3,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic                  m1_we,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [Func3Width-1:0] m1_func3,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  m1_err,
  output logic [ADDR_W-1:0]     memAddr,
  output logic                  memWriteEnable,
  output logic [DATA_W-1:0]     memWriteData,
  output logic [Func3Width-1:0] func3,
  input  logic [DATA_W-1:0]     memReadData
);

  typedef struct packed {
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [Func3Width-1:0] func3;
  } req_t;

  state_t                state_q, state_d;
  logic                  port_q, port_d;
  logic                  ld_q, ld_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [Func3Width-1:0] mem_func3_q, mem_func3_d;

  logic [1:0] arb_gnt;
  req_t       in_req;
  logic       in_mis, in_oor, in_bad;

  dmem_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({m1_valid, m0_valid}),
    .advance (state_q == ST_IDLE),
    .gnt     (arb_gnt)
  );

  assign in_req = arb_gnt[1] ? req_t'{m1_we, m1_addr, m1_wdata, m1_func3}
                             : req_t'{m0_we, m0_addr, m0_wdata, m0_func3};
  assign in_mis = f3_misaligned(in_req.func3, in_req.addr[1:0]);

`ifdef DMEM_MISALIGN_SPLIT_EN
  req_t        req_q, req_d;
  logic [1:0]  cnt_q, cnt_d, cnt_inc, last_idx;
  logic [2:0]  last_off;
  logic [ADDR_W:0] last_byte;

  // Range is judged on the final byte so a split access is all-or-nothing.
  assign last_off  = (in_req.func3[1:0] == 2'd2) ? 3'd3 : (in_req.func3[1:0] == 2'd1) ? 3'd1 : 3'd0;
  assign last_byte = {1'b0, in_req.addr} + {{(ADDR_W-2){1'b0}}, last_off};
  assign in_oor    = last_byte >= (ADDR_W+1)'(MEM_BYTES);
  assign in_bad    = f3_illegal(in_req.we, in_req.func3) || in_oor;
  assign cnt_inc   = cnt_q + 2'd1;
  assign last_idx  = (req_q.func3 == F3_W) ? 2'd3 : 2'd1;
`else
  assign in_oor = in_req.addr >= ADDR_W'(MEM_BYTES);
  assign in_bad = f3_illegal(in_req.we, in_req.func3) || in_oor || in_mis;
`endif

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    ld_d        = ld_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_addr_d  = '0;
    mem_we_d    = 1'b0;
    mem_wdata_d = '0;
    mem_func3_d = '0;
`ifdef DMEM_MISALIGN_SPLIT_EN
    req_d = req_q;
    cnt_d = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          port_d  = arb_gnt[1];
          ld_d    = ~in_req.we;
          err_d   = in_bad;
          rdata_d = '0;
`ifdef DMEM_MISALIGN_SPLIT_EN
          req_d = in_req;
          cnt_d = 2'd0;
`endif
          if (in_bad) begin
            state_d = ST_RESP;
`ifdef DMEM_MISALIGN_SPLIT_EN
          end else if (in_mis) begin
            state_d     = ST_SPLIT;
            mem_addr_d  = in_req.addr;
            mem_we_d    = in_req.we;
            mem_wdata_d = DATA_W'(in_req.wdata[7:0]);
            mem_func3_d = in_req.we ? F3_B : F3_BU;
`endif
          end else begin
            state_d     = ST_ACCESS;
            mem_addr_d  = in_req.addr;
            mem_we_d    = in_req.we;
            mem_wdata_d = in_req.wdata;
            mem_func3_d = in_req.func3;
          end
        end
      end
      ST_ACCESS: begin
        if (ld_q) rdata_d = memReadData;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
`ifdef DMEM_MISALIGN_SPLIT_EN
      ST_SPLIT: begin
        if (ld_q) rdata_d[{cnt_q, 3'b000} +: 8] = memReadData[7:0];
        if (cnt_q == last_idx) begin
          state_d = ST_FIN;
        end else begin
          cnt_d       = cnt_inc;
          mem_addr_d  = req_q.addr + ADDR_W'(cnt_inc);
          mem_we_d    = req_q.we;
          mem_wdata_d = DATA_W'(req_q.wdata[{cnt_inc, 3'b000} +: 8]);
          mem_func3_d = req_q.we ? F3_B : F3_BU;
        end
      end
      ST_FIN: begin
        if (req_q.func3 == F3_H)  rdata_d = {{(DATA_W-16){rdata_q[15]}}, rdata_q[15:0]};
        if (req_q.func3 == F3_HU) rdata_d = {{(DATA_W-16){1'b0}}, rdata_q[15:0]};
        state_d = ST_RESP;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      port_q      <= 1'b0;
      ld_q        <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      mem_func3_q <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      ld_q        <= ld_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      mem_func3_q <= mem_func3_d;
    end
  end

`ifdef DMEM_MISALIGN_SPLIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
      cnt_q <= 2'd0;
    end else begin
      req_q <= req_d;
      cnt_q <= cnt_d;
    end
  end
`endif

  assign memAddr        = mem_addr_q;
  assign memWriteEnable = mem_we_q;
  assign memWriteData   = mem_wdata_q;
  assign func3          = mem_func3_q;

  assign m0_ready  = (state_q == ST_IDLE);
  assign m1_ready  = (state_q == ST_IDLE);
  assign m0_rvalid = (state_q == ST_RESP) && !port_q;
  assign m1_rvalid = (state_q == ST_RESP) && port_q;
  assign m0_rdata  = m0_rvalid ? rdata_q : '0;
  assign m1_rdata  = m1_rvalid ? rdata_q : '0;
  assign m0_err    = m0_rvalid && err_q;
  assign m1_err    = m1_rvalid && err_q;

endmodule
